// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with combinational and registered outputs.
// Optional saturating carry-event counter enabled by macro FULL_ADDER_STATS_EN.
module full_adder #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q
`ifdef FULL_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("full_adder: WIDTH and CNT_W must be >= 1");
    end

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    // Explicit bit-serial carry chain so X/Z inputs propagate bit by bit.
    always_comb begin
        w_c    = '0;
        w_s    = '0;
        w_c[0] = Cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_s[i]   = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    end

    assign S    = w_s;
    assign Cout = w_c[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_c[WIDTH];
        end
    end

    assign S_q    = r_s;
    assign Cout_q = r_cout;

`ifdef FULL_ADDER_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    // Counts cycles with Cout=1, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_c[WIDTH] && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign carry_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: 1-bit and 4-bit instances checked against
// an arithmetic reference; carry counter checked when FULL_ADDER_STATS_EN is set.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, cin1;
    logic       s1, cout1, sq1, coutq1;
    logic [3:0] a4, b4, s4, sq4;
    logic       cin4, cout4, coutq4;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

`ifdef FULL_ADDER_STATS_EN
    logic [15:0] cnt1, cnt4;
    logic [1:0]  cnt_st;
    logic        s_st, cout_st, sq_st, coutq_st;
`endif

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
        .S(s1), .Cout(cout1), .S_q(sq1), .Cout_q(coutq1)
`ifdef FULL_ADDER_STATS_EN
        , .carry_cnt(cnt1)
`endif
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4),
        .S(s4), .Cout(cout4), .S_q(sq4), .Cout_q(coutq4)
`ifdef FULL_ADDER_STATS_EN
        , .carry_cnt(cnt4)
`endif
    );

`ifdef FULL_ADDER_STATS_EN
    full_adder #(.WIDTH(1), .CNT_W(2)) u_dut_st (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
        .S(s_st), .Cout(cout_st), .S_q(sq_st), .Cout_q(coutq_st),
        .carry_cnt(cnt_st)
    );
`endif

    // Reference: plain integer addition at WIDTH+1 bits, result is {Cout,S}.
    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return 5'(a) + 5'(b) + 5'(c);
    endfunction

    task automatic test_reset();
        logic [4:0] e4;
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sq1 !== 1'b0 || coutq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_reg1: got S_q=%b Cout_q=%b want 0 0", sq1, coutq1);
        end
        checks++;
        if (sq4 !== 4'h0 || coutq4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_reg4: got S_q=%h Cout_q=%b want 0 0", sq4, coutq4);
        end
        checks++;
        if (s1 !== 1'b0 || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb1: got S=%b Cout=%b want 0 1", s1, cout1);
        end
        e4 = ref4(a4, b4, cin4);
        checks++;
        if ({cout4, s4} !== e4) begin
            errors++;
            $display("FAIL reset_comb4: got %h want %h", {cout4, s4}, e4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [2:0] v;
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            #1;
            e = ref1(a1, b1, cin1);
            checks++;
            if ({cout1, s1} !== e) begin
                errors++;
                $display("FAIL truth_table[%0d]: got C=%b S=%b want C=%b S=%b",
                         i, cout1, s1, e[1], e[0]);
            end
            #49;
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        #1;
        checks++;
        if (s1 !== 1'b0 || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL latency_comb: got S=%b Cout=%b want 0 1", s1, cout1);
        end
        checks++;
        if (sq1 !== 1'b0 || coutq1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_hold: got S_q=%b Cout_q=%b want 0 0", sq1, coutq1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sq1 !== 1'b0 || coutq1 !== 1'b1) begin
            errors++;
            $display("FAIL latency_reg: got S_q=%b Cout_q=%b want 0 1", sq1, coutq1);
        end
    endtask

    task automatic test_wide();
        logic [3:0] ta [3] = '{4'hF, 4'h7, 4'hF};
        logic [3:0] tb [3] = '{4'h0, 4'h8, 4'hF};
        logic       tc [3] = '{1'b1, 1'b0, 1'b1};
        logic [4:0] te [3] = '{5'h10, 5'h0F, 5'h1F};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = ta[i]; b4 = tb[i]; cin4 = tc[i];
            #1;
            checks++;
            if ({cout4, s4} !== te[i]) begin
                errors++;
                $display("FAIL wide_comb[%0d]: got C=%b S=%h want C=%b S=%h",
                         i, cout4, s4, te[i][4], te[i][3:0]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({coutq4, sq4} !== te[i]) begin
                errors++;
                $display("FAIL wide_reg[%0d]: got C=%b S=%h want C=%b S=%h",
                         i, coutq4, sq4, te[i][4], te[i][3:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e1, r1;
        logic [4:0] e4, r4;
        bit         have_prev = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (have_prev) begin
                checks++;
                if ({coutq1, sq1} !== r1 || {coutq4, sq4} !== r4) begin
                    errors++;
                    $display("FAIL b2b_reg[%0d]: got w1=%b w4=%h want w1=%b w4=%h",
                             k, {coutq1, sq1}, {coutq4, sq4}, r1, r4);
                end
            end
            rst_n = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            if (k % 7 == 0) begin
                a4 = 4'hF; cin4 = 1'b1;
            end
            #1;
            e1 = ref1(a1, b1, cin1);
            e4 = ref4(a4, b4, cin4);
            checks++;
            if ({cout1, s1} !== e1 || {cout4, s4} !== e4) begin
                errors++;
                $display("FAIL b2b_comb[%0d]: got w1=%b w4=%h want w1=%b w4=%h",
                         k, {cout1, s1}, {cout4, s4}, e1, e4);
            end
            r1 = rst_n ? e1 : 2'b00;
            r4 = rst_n ? e4 : 5'h00;
            have_prev = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef FULL_ADDER_STATS_EN
    task automatic test_stats();
        int unsigned m;
        logic [1:0]  e;
        @(negedge clk);
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m = 0;
        checks++;
        if (cnt_st !== 2'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d want 0", cnt_st);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            m = (m + 1 > 3) ? 3 : m + 1;
            checks++;
            if (cnt_st !== 2'(m)) begin
                errors++;
                $display("FAIL stats_sat[%0d]: got %0d want %0d", k, cnt_st, m);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m = 0;
        checks++;
        if (cnt_st !== 2'd0) begin
            errors++;
            $display("FAIL stats_pulse: got %0d want 0", cnt_st);
        end
        for (int k = 0; k < 20; k++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            e = ref1(a1, b1, cin1);
            @(negedge clk);
            if (e[1] && m < 3) m = m + 1;
            checks++;
            if (cnt_st !== 2'(m)) begin
                errors++;
                $display("FAIL stats_rand[%0d]: got %0d want %0d", k, cnt_st, m);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        test_reset();
        test_truth_table();
        test_latency();
        test_wide();
        test_back_to_back();
`ifdef FULL_ADDER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
